axi_wr_arbiter: RTL and testbench

Two-requester arbiter that shares one downstream AXI4 write path (AW, W, B) between two upstream masters, one complete write transaction at a time. It sits in front of the write side of an AXI register slice or slave port. It sequences each granted burst through address, data and response phases, and generates the downstream WLAST from its own beat count.

---
 rtl/axi_wr_arbiter_if.sv | 68 ++++++
 rtl/axi_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_arbiter_if.sv
// Signal bundle for axi_wr_arbiter: two packed upstream AXI4 write ports (port 0 in the low slice)
// plus the shared downstream write port. slave is the arbiter's view, master the surrounding system's.
interface axi_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
);
    logic [2*ID_WIDTH-1:0]   s_axi_awid;
    logic [2*ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [2*8-1:0]          s_axi_awlen;
    logic [1:0]              s_axi_awvalid;
    logic [1:0]              s_axi_awready;
    logic [2*DATA_WIDTH-1:0] s_axi_wdata;
    logic [2*STRB_WIDTH-1:0] s_axi_wstrb;
    logic [1:0]              s_axi_wlast;
    logic [1:0]              s_axi_wvalid;
    logic [1:0]              s_axi_wready;
    logic [ID_WIDTH-1:0]     s_axi_bid;
    logic [1:0]              s_axi_bresp;
    logic [1:0]              s_axi_bvalid;
    logic [1:0]              s_axi_bready;

    logic [ID_WIDTH-1:0]     m_axi_awid;
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [7:0]              m_axi_awlen;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [STRB_WIDTH-1:0]   m_axi_wstrb;
    logic                    m_axi_wlast;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [ID_WIDTH-1:0]     m_axi_bid;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-port AXI4 write arbiter: one complete AW/W/B transaction at a time, WLAST generated from a beat count.
// Define AXI_WR_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module axi_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_wr_arbiter_if.slave        bus,
    output logic [1:0]             grant,
    output logic                   wlast_err
);

`ifdef AXI_WR_ARB_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ARB, AW, W, B} state_t;

    state_t     state;
    logic       last_grant;
    logic [7:0] beat_cnt;
    logic [7:0] len_q;

    logic       sel;
    logic       win;
    logic [1:0] req;
    logic       in_aw, in_w, in_b;
    logic       awvalid_g, wvalid_g, wlast_g, bready_g;
    logic       aw_hs, w_hs, b_hs;
    logic       last_beat;
    logic [7:0] awlen_g;

    // grant is one-hot and only non-zero outside IDLE, so its high bit is the owning port index.
    assign sel = grant[1];
    assign req = bus.s_axi_awvalid;

    assign in_aw = (state == AW);
    assign in_w  = (state == W);
    assign in_b  = (state == B);

    assign awvalid_g = bus.s_axi_awvalid[sel];
    assign wvalid_g  = bus.s_axi_wvalid[sel];
    assign wlast_g   = bus.s_axi_wlast[sel];
    assign bready_g  = bus.s_axi_bready[sel];
    assign awlen_g   = sel ? bus.s_axi_awlen[15:8] : bus.s_axi_awlen[7:0];

    assign aw_hs     = in_aw & awvalid_g & bus.m_axi_awready;
    assign w_hs      = in_w & wvalid_g & bus.m_axi_wready;
    assign b_hs      = in_b & bus.m_axi_bvalid & bready_g;
    assign last_beat = in_w & (beat_cnt == len_q);

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        win = ~req[0];
        if (RR_ON && req == 2'b11) begin
            win = ~last_grant;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            beat_cnt   <= 8'd0;
            len_q      <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= win ? 2'b10 : 2'b01;
                        state <= ARB;
                    end
                end
                ARB: state <= AW;
                AW: begin
                    if (aw_hs) begin
                        len_q    <= awlen_g;
                        beat_cnt <= 8'd0;
                        state    <= W;
                    end
                end
                W: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (last_beat) begin
                            state <= B;
                        end
                    end
                end
                B: begin
                    if (b_hs) begin
                        last_grant <= sel;
                        grant      <= 2'b00;
                        state      <= IDLE;
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Channel routing: payloads always follow the owner, valids/readies are gated by the phase.
    always_comb begin
        bus.m_axi_awid   = sel ? bus.s_axi_awid[2*ID_WIDTH-1:ID_WIDTH]
                               : bus.s_axi_awid[ID_WIDTH-1:0];
        bus.m_axi_awaddr = sel ? bus.s_axi_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : bus.s_axi_awaddr[ADDR_WIDTH-1:0];
        bus.m_axi_awlen  = awlen_g;
        bus.m_axi_awvalid = in_aw & awvalid_g;
        bus.s_axi_awready = 2'b00;
        bus.s_axi_awready[sel] = in_aw & bus.m_axi_awready;

        bus.m_axi_wdata  = sel ? bus.s_axi_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : bus.s_axi_wdata[DATA_WIDTH-1:0];
        bus.m_axi_wstrb  = sel ? bus.s_axi_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                               : bus.s_axi_wstrb[STRB_WIDTH-1:0];
        bus.m_axi_wlast  = last_beat;
        bus.m_axi_wvalid = in_w & wvalid_g;
        bus.s_axi_wready = 2'b00;
        bus.s_axi_wready[sel] = in_w & bus.m_axi_wready;

        bus.s_axi_bid    = bus.m_axi_bid;
        bus.s_axi_bresp  = bus.m_axi_bresp;
        bus.m_axi_bready = in_b & bready_g;
        bus.s_axi_bvalid = 2'b00;
        bus.s_axi_bvalid[sel] = in_b & bus.m_axi_bvalid;

        // The requester's WLAST is only compared; the burst length always comes from awlen.
        wlast_err = w_hs & (wlast_g != last_beat);
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized self-checking bench for axi_wr_arbiter; expectations come from a transaction-level model.
module tb_axi_wr_arbiter;
    localparam int DW   = 32;
    localparam int AWD  = 32;
    localparam int SW   = DW / 8;
    localparam int IW   = 8;
    localparam int SW2  = 2 * SW;
`ifdef AXI_WR_ARB_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       wlast_err;

    int errors = 0;
    int checks = 0;
    int model_last = 1;

    axi_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .STRB_WIDTH(SW), .ID_WIDTH(IW)) bus ();

    axi_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant     (grant),
        .wlast_err (wlast_err)
    );

    always #5 clk = ~clk;

    function automatic int exp_winner(input logic [1:0] req);
        if (RR_ON && req == 2'b11) return (model_last == 0) ? 1 : 0;
        return req[0] ? 0 : 1;
    endfunction

    function automatic logic [12:0] ctrl_outputs();
        return {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast, bus.m_axi_bready,
                bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid, grant, wlast_err};
    endfunction

    task automatic idle_inputs();
        bus.s_axi_awid    = '0;
        bus.s_axi_awaddr  = '0;
        bus.s_axi_awlen   = '0;
        bus.s_axi_awvalid = '0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wstrb   = '0;
        bus.s_axi_wlast   = '0;
        bus.s_axi_wvalid  = '0;
        bus.s_axi_bready  = '0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bid     = '0;
        bus.m_axi_bresp   = '0;
        bus.m_axi_bvalid  = 1'b0;
    endtask

    // Plays both requesters and the downstream slave for one transaction starting in IDLE.
    // flip: 1-based beat on which the owner's WLAST is inverted (0 = correct WLAST throughout).
    // wr_mode: 0 random m_axi_wready, 1 toggling, 2 always high. rst_after > 0 resets after that many beats.
    task automatic run_txn(input string name, input logic [1:0] req, input logic [7:0] len0,
                           input logic [7:0] len1, input int flip, input int wr_mode,
                           input int rst_after);
        int w, cyc, beats, aw_seen, wlast_cnt, wlast_beat, err_cnt, err_beat, exp_err;
        int grant_bad, aw_bad, w_bad, b_bad, err_bad;
        logic [7:0] len;
        logic [IW-1:0] id0, id1, exp_id;
        logic [AWD-1:0] addr0, addr1, exp_addr;
        logic [1:0] onehot, exp_g, wv, wl;
        logic [DW-1:0] exp_data;
        logic [SW-1:0] exp_strb;
        bit aw_done, b_done, aborted, in_aw, in_w, in_b, s_last;
        bit exp_awhs, exp_whs, exp_bhs, exp_mwvalid, exp_mwlast, exp_mbready;
        logic [1:0] exp_awready, exp_wready, exp_bvalid;

        w = exp_winner(req);
        len = (w == 1) ? len1 : len0;
        onehot = (w == 1) ? 2'b10 : 2'b01;
        id0 = IW'($urandom);
        id1 = IW'($urandom);
        addr0 = $urandom;
        addr1 = $urandom;
        exp_id = (w == 1) ? id1 : id0;
        exp_addr = (w == 1) ? addr1 : addr0;
        exp_err = (flip >= 1 && flip <= int'(len) + 1) ? 1 : 0;
        cyc = 0; beats = 0; aw_seen = -1; wlast_cnt = 0; wlast_beat = -1;
        err_cnt = 0; err_beat = -1;
        grant_bad = 0; aw_bad = 0; w_bad = 0; b_bad = 0; err_bad = 0;
        aw_done = 0; b_done = 0; aborted = 0;

        bus.s_axi_awid    = {id1, id0};
        bus.s_axi_awaddr  = {addr1, addr0};
        bus.s_axi_awlen   = {len1, len0};
        bus.s_axi_awvalid = req;

        while (!b_done && cyc < 3000) begin
            if (rst_after > 0 && aw_done && beats == rst_after) begin
                idle_inputs();
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                checks++;
                if (ctrl_outputs() !== '0) begin
                    errors++;
                    $display("FAIL %s outputs_after_reset: got %b want 0", name, ctrl_outputs());
                end
                model_last = 1;
                @(posedge clk);
                #1;
                aborted = 1;
                break;
            end
            in_aw = (cyc >= 2) && !aw_done;
            in_w  = aw_done && (beats <= int'(len));
            in_b  = aw_done && (beats == int'(len) + 1);
            s_last = (beats + 1 == int'(len) + 1) ^ (beats + 1 == flip);

            bus.m_axi_awready = 1'($urandom_range(0, 1));
            case (wr_mode)
                1: bus.m_axi_wready = 1'(cyc % 2);
                2: bus.m_axi_wready = 1'b1;
                default: bus.m_axi_wready = 1'($urandom_range(0, 1));
            endcase
            bus.s_axi_wdata = {$urandom, $urandom};
            bus.s_axi_wstrb = SW2'($urandom);
            wv = (in_w && $urandom_range(0, 3) != 0) ? onehot : 2'b00;
            wv |= 2'($urandom) & ~onehot;
            wl = s_last ? onehot : 2'b00;
            wl |= 2'($urandom) & ~onehot;
            bus.s_axi_wvalid = wv;
            bus.s_axi_wlast  = wl;
            bus.m_axi_bvalid = in_b ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.m_axi_bid    = IW'($urandom);
            bus.m_axi_bresp  = 2'($urandom);
            bus.s_axi_bready = 2'($urandom);

            @(negedge clk);
            exp_g = (cyc == 0) ? 2'b00 : onehot;
            if (grant !== exp_g) grant_bad++;

            exp_awready = (in_aw && bus.m_axi_awready) ? onehot : 2'b00;
            if (bus.m_axi_awvalid !== in_aw) aw_bad++;
            if (bus.s_axi_awready !== exp_awready) aw_bad++;
            if (in_aw && (bus.m_axi_awid !== exp_id || bus.m_axi_awaddr !== exp_addr ||
                          bus.m_axi_awlen !== len)) aw_bad++;
            if (bus.m_axi_awvalid === 1'b1 && aw_seen < 0) aw_seen = cyc;

            exp_mwvalid = in_w && ((bus.s_axi_wvalid & onehot) != 2'b00);
            exp_wready  = (in_w && bus.m_axi_wready) ? onehot : 2'b00;
            exp_mwlast  = in_w && (beats == int'(len));
            exp_data = (w == 1) ? bus.s_axi_wdata[2*DW-1:DW] : bus.s_axi_wdata[DW-1:0];
            exp_strb = (w == 1) ? bus.s_axi_wstrb[2*SW-1:SW] : bus.s_axi_wstrb[SW-1:0];
            if (bus.m_axi_wvalid !== exp_mwvalid) w_bad++;
            if (bus.s_axi_wready !== exp_wready) w_bad++;
            if (bus.m_axi_wlast !== exp_mwlast) w_bad++;
            if (exp_mwvalid && (bus.m_axi_wdata !== exp_data || bus.m_axi_wstrb !== exp_strb)) w_bad++;
            exp_whs = exp_mwvalid && bus.m_axi_wready;
            if (exp_whs && bus.m_axi_wlast === 1'b1) begin
                wlast_cnt++;
                wlast_beat = beats + 1;
            end
            if (wlast_err === 1'b1) begin
                err_cnt++;
                err_beat = beats + 1;
                if (!exp_whs) err_bad++;
            end

            exp_mbready = in_b && ((bus.s_axi_bready & onehot) != 2'b00);
            exp_bvalid  = (in_b && bus.m_axi_bvalid) ? onehot : 2'b00;
            if (bus.s_axi_bvalid !== exp_bvalid) b_bad++;
            if (bus.m_axi_bready !== exp_mbready) b_bad++;
            if (in_b && (bus.s_axi_bid !== bus.m_axi_bid || bus.s_axi_bresp !== bus.m_axi_bresp)) b_bad++;
            exp_bhs  = exp_mbready && bus.m_axi_bvalid;
            exp_awhs = in_aw && bus.m_axi_awready;

            @(posedge clk);
            #1;
            if (exp_awhs) begin
                aw_done = 1;
                bus.s_axi_awvalid &= ~onehot;
            end
            if (exp_whs) beats++;
            if (exp_bhs) begin
                b_done = 1;
                model_last = w;
            end
            cyc++;
        end

        checks++;
        if (grant_bad !== 0) begin
            errors++;
            $display("FAIL %s grant: %0d bad cycles, want 0 (expected owner %0d)", name, grant_bad, w);
        end
        checks++;
        if (aw_bad !== 0) begin
            errors++;
            $display("FAIL %s aw_channel: %0d bad cycles, want 0", name, aw_bad);
        end
        checks++;
        if (w_bad !== 0) begin
            errors++;
            $display("FAIL %s w_channel: %0d bad cycles, want 0", name, w_bad);
        end
        checks++;
        if (b_bad !== 0) begin
            errors++;
            $display("FAIL %s b_channel: %0d bad cycles, want 0", name, b_bad);
        end
        checks++;
        if (err_bad !== 0) begin
            errors++;
            $display("FAIL %s wlast_err_timing: %0d stray pulses, want 0", name, err_bad);
        end
        if (!aborted) begin
            checks++;
            if (b_done !== 1'b1) begin
                errors++;
                $display("FAIL %s completion: timed out after %0d cycles with %0d beats, want done", name, cyc, beats);
            end
            checks++;
            if (aw_seen !== 2) begin
                errors++;
                $display("FAIL %s aw_latency: got %0d cycles, want 2", name, aw_seen);
            end
            checks++;
            if (wlast_cnt !== 1 || wlast_beat !== int'(len) + 1) begin
                errors++;
                $display("FAIL %s m_wlast: seen %0d times, last on beat %0d, want once on beat %0d",
                         name, wlast_cnt, wlast_beat, int'(len) + 1);
            end
            checks++;
            if (err_cnt !== exp_err) begin
                errors++;
                $display("FAIL %s wlast_err_count: got %0d want %0d", name, err_cnt, exp_err);
            end
            if (exp_err > 0) begin
                checks++;
                if (err_beat !== flip) begin
                    errors++;
                    $display("FAIL %s wlast_err_beat: got %0d want %0d", name, err_beat, flip);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_outputs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", ctrl_outputs());
        end
        model_last = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        run_txn("single_p0", 2'b01, 8'd3, 8'd0, 0, 2, 0);
    endtask

    task automatic test_arbitration();
        for (int i = 0; i < 3; i++) begin
            run_txn("tie", 2'b11, 8'd0, 8'd0, 0, 0, 0);
        end
    endtask

    task automatic test_wlast_err();
        run_txn("early_wlast_p1", 2'b10, 8'd0, 8'd3, 2, 2, 0);
        run_txn("missing_wlast_p0", 2'b01, 8'd5, 8'd0, 6, 0, 0);
    endtask

    task automatic test_long_burst();
        run_txn("len255_toggle", 2'b01, 8'd255, 8'd0, 0, 1, 0);
    endtask

    task automatic test_reset_mid_burst();
        run_txn("pre_reset_p0", 2'b01, 8'd1, 8'd0, 0, 2, 0);
        run_txn("reset_mid_w", 2'b10, 8'd0, 8'd6, 0, 2, 2);
        run_txn("post_reset_tie", 2'b11, 8'd2, 8'd2, 0, 0, 0);
    endtask

    task automatic test_wvalid_isolation();
        run_txn("iso_p1_first", 2'b10, 8'd0, 8'd1, 0, 0, 0);
        run_txn("iso_p0_owns", 2'b11, 8'd4, 8'd2, 0, 0, 0);
        run_txn("iso_p1_after", 2'b10, 8'd0, 8'd2, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [1:0] req;
        logic [7:0] l0, l1, lw;
        int flip;
        for (int i = 0; i < 12; i++) begin
            req = 2'($urandom_range(1, 3));
            l0 = 8'($urandom_range(0, 15));
            l1 = 8'($urandom_range(0, 15));
            lw = (exp_winner(req) == 1) ? l1 : l0;
            flip = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, int'(lw) + 1)) : 0;
            run_txn("random", req, l0, l1, flip, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_wlast_err();
        test_long_burst();
        test_reset_mid_burst();
        test_wvalid_isolation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
